// File: rtl/rv32_alu_logical_pipe.sv
// Pipelined RV32I logical unit (AND/OR/XOR) with valid/ready, flush and tag.
// Define ALU_LOGICAL_ZBB_EN to add Zbb ANDN/ORN/XNOR (opsel 20/21/22).
module rv32_alu_logical_pipe #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [XLEN-1:0]  in_opA,
  input  logic [XLEN-1:0]  in_opB,
  input  logic [4:0]       in_opsel,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_result,
  output logic             out_zero,
  output logic [TAG_W-1:0] out_tag
);

  if (DEPTH < 1 || DEPTH > 4) begin : g_bad_depth
    $error("DEPTH must be in 1..4");
  end
  if (XLEN < 8) begin : g_bad_xlen
    $error("XLEN must be >= 8");
  end

  logic is_and, is_or, is_xor;
  logic is_andn, is_orn, is_xnor;
  logic [XLEN-1:0] dec_res;

  assign is_and = (in_opsel == 5'd2) || (in_opsel == 5'd9);
  assign is_or  = (in_opsel == 5'd3) || (in_opsel == 5'd10);
  assign is_xor = (in_opsel == 5'd4) || (in_opsel == 5'd11);
`ifdef ALU_LOGICAL_ZBB_EN
  assign is_andn = (in_opsel == 5'd20);
  assign is_orn  = (in_opsel == 5'd21);
  assign is_xnor = (in_opsel == 5'd22);
`else
  assign is_andn = 1'b0;
  assign is_orn  = 1'b0;
  assign is_xnor = 1'b0;
`endif

  always_comb begin
    dec_res = '0;
    unique case (1'b1)
      is_and:  dec_res = in_opA & in_opB;
      is_or:   dec_res = in_opA | in_opB;
      is_xor:  dec_res = in_opA ^ in_opB;
      is_andn: dec_res = in_opA & ~in_opB;
      is_orn:  dec_res = in_opA | ~in_opB;
      is_xnor: dec_res = ~(in_opA ^ in_opB);
      default: dec_res = '0;
    endcase
  end

  logic [DEPTH-1:0]            valid_q;
  logic [DEPTH-1:0][XLEN-1:0]  result_q;
  logic [DEPTH-1:0]            zero_q;
  logic [DEPTH-1:0][TAG_W-1:0] tag_q;

  logic [DEPTH-1:0]            up_valid;
  logic [DEPTH-1:0][XLEN-1:0]  up_result;
  logic [DEPTH-1:0]            up_zero;
  logic [DEPTH-1:0][TAG_W-1:0] up_tag;

  logic [DEPTH:0] ready;
  logic           rdy_chain;

  // Ready ripples back from the output; an empty stage always accepts.
  always_comb begin
    rdy_chain    = out_ready;
    ready        = '0;
    ready[DEPTH] = out_ready;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      rdy_chain = !valid_q[i] || rdy_chain;
      ready[i]  = rdy_chain;
    end
  end

  assign in_ready = ready[0] && !flush;

  always_comb begin
    up_valid[0]  = in_valid;
    up_result[0] = dec_res;
    up_zero[0]   = (dec_res == '0);
    up_tag[0]    = in_tag;
    for (int i = 1; i < DEPTH; i++) begin
      up_valid[i]  = valid_q[i-1];
      up_result[i] = result_q[i-1];
      up_zero[i]   = zero_q[i-1];
      up_tag[i]    = tag_q[i-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q  <= '0;
      result_q <= '0;
      zero_q   <= '0;
      tag_q    <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (flush) begin
          valid_q[i] <= 1'b0;
        end else if (ready[i]) begin
          valid_q[i] <= up_valid[i];
          if (up_valid[i]) begin
            result_q[i] <= up_result[i];
            zero_q[i]   <= up_zero[i];
            tag_q[i]    <= up_tag[i];
          end
        end
      end
    end
  end

  assign out_valid  = valid_q[DEPTH-1];
  assign out_result = result_q[DEPTH-1];
  assign out_zero   = zero_q[DEPTH-1];
  assign out_tag    = tag_q[DEPTH-1];

endmodule
